// File: rtl/demux_1x2_buf_if.sv
// rtl/demux_1x2_buf_if.sv - source and dual-sink handshake bundle for demux_1x2_buf
interface demux_1x2_buf_if #(
    parameter int WIDTH = 16,
    parameter int CW    = 2
);
    logic             IN_VALID;
    logic             IN_READY;
    logic             S;
    logic [WIDTH-1:0] D;

    logic             O1_VALID;
    logic             O1_READY;
    logic [WIDTH-1:0] O1;
    logic [CW-1:0]    O1_COUNT;

    logic             O2_VALID;
    logic             O2_READY;
    logic [WIDTH-1:0] O2;
    logic [CW-1:0]    O2_COUNT;

    // Environment side: drives the source stream and both sink readies.
    modport master (
        output IN_VALID, S, D, O1_READY, O2_READY,
        input  IN_READY, O1_VALID, O1, O1_COUNT, O2_VALID, O2, O2_COUNT
    );

    // Demux side.
    modport slave (
        input  IN_VALID, S, D, O1_READY, O2_READY,
        output IN_READY, O1_VALID, O1, O1_COUNT, O2_VALID, O2, O2_COUNT
    );
endinterface

// File: rtl/demux_1x2_buf.sv
// rtl/demux_1x2_buf.sv - 1-to-2 stream demux with an independent FIFO per output
module demux_1x2_buf #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic           CLK,
    input  logic           RST,
    demux_1x2_buf_if.slave bus
);
    localparam int PW = $clog2(DEPTH);

    logic [1:0]       push;
    logic [1:0]       pop;
    logic [1:0]       full;
    logic [1:0]       empty;
    logic [1:0]       sink_ready;
    logic             in_ready;
    logic [WIDTH-1:0] head [2];
    logic [CW-1:0]    cnt  [2];

    // Ready looks only at the selected FIFO's full flag; a same-cycle pop does not free a slot.
    always_comb begin
        in_ready   = bus.S ? !full[1] : !full[0];
        push       = 2'b00;
        sink_ready = {bus.O2_READY, bus.O1_READY};
        if (bus.IN_VALID && in_ready) begin
            push[bus.S] = 1'b1;
        end
        pop = ~empty & sink_ready;
    end

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        logic [WIDTH-1:0] mem [DEPTH];
        logic [PW-1:0]    wr_ptr;
        logic [PW-1:0]    rd_ptr;
        logic [CW-1:0]    count;

        always_ff @(posedge CLK) begin
            if (RST) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push[g]) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop[g]) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                case ({push[g], pop[g]})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end

        // Storage needs no reset: the pointers and count define what is valid.
        always_ff @(posedge CLK) begin
            if (!RST && push[g]) begin
                mem[wr_ptr] <= bus.D;
            end
        end

        assign full[g]  = (count == CW'(DEPTH));
        assign empty[g] = (count == '0);
        assign head[g]  = empty[g] ? '0 : mem[rd_ptr];
        assign cnt[g]   = count;
    end

    assign bus.IN_READY = in_ready;
    assign bus.O1_VALID = !empty[0];
    assign bus.O1       = head[0];
    assign bus.O1_COUNT = cnt[0];
    assign bus.O2_VALID = !empty[1];
    assign bus.O2       = head[1];
    assign bus.O2_COUNT = cnt[1];
endmodule

// File: tb/tb_demux_1x2_buf.sv
// tb/tb_demux_1x2_buf.sv - scoreboard bench for demux_1x2_buf
module tb_demux_1x2_buf;
    localparam int WIDTH = 16;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic CLK;
    logic RST;

    demux_1x2_buf_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

    demux_1x2_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    bit last_acc = 1'b0;
    logic [WIDTH-1:0] q1 [$];
    logic [WIDTH-1:0] q2 [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: compare outputs against the scoreboard at the falling edge, then advance the model at the rising edge.
    task automatic cyc();
        logic exp_rdy;
        logic acc;
        logic p1;
        logic p2;
        @(negedge CLK);
        exp_rdy = bus.S ? (q2.size() < DEPTH) : (q1.size() < DEPTH);
        if (chk_en) begin
            check("in_ready", bus.IN_READY, exp_rdy);
            check("o1_valid", bus.O1_VALID, q1.size() != 0);
            check("o1_count", bus.O1_COUNT, q1.size());
            if (q1.size() != 0) check("o1_data", bus.O1, q1[0]);
            check("o2_valid", bus.O2_VALID, q2.size() != 0);
            check("o2_count", bus.O2_COUNT, q2.size());
            if (q2.size() != 0) check("o2_data", bus.O2, q2[0]);
        end
        acc = bus.IN_VALID && exp_rdy;
        p1  = (q1.size() != 0) && bus.O1_READY;
        p2  = (q2.size() != 0) && bus.O2_READY;
        @(posedge CLK);
        if (RST) begin
            q1.delete();
            q2.delete();
            last_acc = 1'b0;
        end else begin
            if (p1) void'(q1.pop_front());
            if (p2) void'(q2.pop_front());
            if (acc) begin
                if (bus.S) q2.push_back(bus.D);
                else       q1.push_back(bus.D);
            end
            last_acc = acc;
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [WIDTH-1:0] d);
        bus.IN_VALID = v;
        bus.S        = s;
        bus.D        = d;
    endtask

    initial begin
        int n;
        int guard;
        RST          = 1'b1;
        bus.O1_READY = 1'b1;
        bus.O2_READY = 1'b1;
        drive(1'b1, 1'b0, 16'hDEAD);

        // Reset held two cycles with a word offered: nothing may be captured.
        cyc();
        chk_en = 1'b1;
        cyc();
        check("rst_o1_zero", bus.O1, 16'h0000);
        check("rst_o2_zero", bus.O2, 16'h0000);
        RST = 1'b0;
        drive(1'b0, 1'b0, 16'h0000);
        cyc();

        // Routing by S.
        drive(1'b1, 1'b0, 16'h1111);
        cyc();
        drive(1'b1, 1'b1, 16'h2222);
        cyc();
        drive(1'b0, 1'b0, 16'h0000);
        repeat (3) cyc();

        // Backpressure on output 1; output 2 keeps flowing.
        bus.O1_READY = 1'b0;
        drive(1'b1, 1'b0, 16'hA001);
        cyc();
        drive(1'b1, 1'b0, 16'hA002);
        cyc();
        drive(1'b1, 1'b0, 16'hA003);
        cyc();
        check("full_refuse", {31'd0, last_acc}, 32'd0);
        drive(1'b1, 1'b1, 16'hB001);
        cyc();
        drive(1'b0, 1'b0, 16'h0000);
        cyc();
        bus.O1_READY = 1'b1;
        repeat (3) cyc();

        // Full FIFO popped while a push is offered: refused this cycle, taken the next.
        bus.O1_READY = 1'b0;
        drive(1'b1, 1'b0, 16'hC001);
        cyc();
        drive(1'b1, 1'b0, 16'hC002);
        cyc();
        bus.O1_READY = 1'b1;
        drive(1'b1, 1'b0, 16'hC003);
        cyc();
        check("full_pop_refuse", {31'd0, last_acc}, 32'd0);
        cyc();
        check("full_pop_accept", {31'd0, last_acc}, 32'd1);
        drive(1'b0, 1'b0, 16'h0000);
        repeat (3) cyc();

        // Pointer wrap: ten words with the sink toggling every cycle.
        n     = 0;
        guard = 0;
        while (n < 10 && guard < 60) begin
            drive(1'b1, 1'b0, WIDTH'(n));
            bus.O1_READY = ~bus.O1_READY;
            cyc();
            if (last_acc) n++;
            guard++;
        end
        check("wrap_all_pushed", n, 10);
        drive(1'b0, 1'b0, 16'h0000);
        bus.O1_READY = 1'b1;
        repeat (4) cyc();
        check("wrap_drained", q1.size(), 0);

        // Reset with both FIFOs full and both sinks ready: contents discarded.
        bus.O1_READY = 1'b0;
        bus.O2_READY = 1'b0;
        drive(1'b1, 1'b0, 16'hE001);
        cyc();
        drive(1'b1, 1'b0, 16'hE002);
        cyc();
        drive(1'b1, 1'b1, 16'hF001);
        cyc();
        drive(1'b1, 1'b1, 16'hF002);
        cyc();
        drive(1'b0, 1'b0, 16'h0000);
        bus.O1_READY = 1'b1;
        bus.O2_READY = 1'b1;
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        cyc();
        check("mid_rst_o1_count", bus.O1_COUNT, 0);
        check("mid_rst_o2_count", bus.O2_COUNT, 0);
        drive(1'b1, 1'b1, 16'h7777);
        cyc();
        drive(1'b0, 1'b0, 16'h0000);
        repeat (2) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
